// File: rtl/riscv_alu_exec_unit_if.sv
// Request/response bundle for the ALU execute unit, plus a debug view of its FSM state.
// Handshake: a request transfers on a rising edge where in_valid && in_ready. A result transfers on a
// rising edge where out_valid && out_ready. A valid is held until its transfer edge.
interface riscv_alu_exec_unit_if #(
    parameter int XLEN = 32
);
    logic            in_valid;
    logic            in_ready;
    logic [1:0]      ALUop;
    logic [6:0]      fun7;
    logic [2:0]      fun3;
    logic [XLEN-1:0] op_a;
    logic [XLEN-1:0] op_b;
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] result;
    logic            zero;
    logic [3:0]      alu_ctrl;
    logic            illegal;
    logic [1:0]      state_dbg;

    modport master (
        output in_valid, ALUop, fun7, fun3, op_a, op_b, out_ready,
        input  in_ready, out_valid, result, zero, alu_ctrl, illegal, state_dbg
    );

    modport slave (
        input  in_valid, ALUop, fun7, fun3, op_a, op_b, out_ready,
        output in_ready, out_valid, result, zero, alu_ctrl, illegal, state_dbg
    );
endinterface

// File: rtl/riscv_alu_exec_unit.sv
// RV32I-style execute unit: decodes {ALUop,fun7,fun3} into a 4-bit control code, computes the result
// in one cycle, or runs an XLEN-step shift-add multiply, behind valid/ready handshakes.
module riscv_alu_exec_unit #(
    parameter int XLEN       = 32,
    parameter bit ENABLE_MUL = 1'b1
) (
    input logic                   clk,
    input logic                   rst,
    riscv_alu_exec_unit_if.slave  bus
);
    localparam int CW = $clog2(XLEN);

    localparam logic [3:0] C_AND  = 4'b0000;
    localparam logic [3:0] C_OR   = 4'b0001;
    localparam logic [3:0] C_ADD  = 4'b0010;
    localparam logic [3:0] C_XOR  = 4'b0011;
    localparam logic [3:0] C_SLL  = 4'b0100;
    localparam logic [3:0] C_SRL  = 4'b0101;
    localparam logic [3:0] C_SUB  = 4'b0110;
    localparam logic [3:0] C_SRA  = 4'b0111;
    localparam logic [3:0] C_SLT  = 4'b1000;
    localparam logic [3:0] C_SLTU = 4'b1001;
    localparam logic [3:0] C_MUL  = 4'b1010;
    localparam logic [3:0] C_ILL  = 4'b1111;

    typedef enum logic [1:0] {IDLE = 2'd0, MUL_BUSY = 2'd1, DONE = 2'd2} state_t;

    state_t          state_q, state_d;
    logic [XLEN-1:0] result_q, result_d;
    logic [3:0]      alu_ctrl_q, alu_ctrl_d;
    logic            zero_q, zero_d;
    logic            illegal_q, illegal_d;
    logic [XLEN-1:0] mcand_q, mcand_d;
    logic [XLEN-1:0] mplier_q, mplier_d;
    logic [XLEN-1:0] acc_q, acc_d;
    logic [CW-1:0]   cnt_q, cnt_d;

    logic [3:0]      ctrl_dec;
    logic [XLEN-1:0] alu_res;
    logic [XLEN-1:0] step_sum;
    logic [CW-1:0]   shamt;

    always_comb begin
        ctrl_dec = C_ILL;
        case (bus.ALUop)
            2'b00: ctrl_dec = C_ADD;
            2'b01: ctrl_dec = C_SUB;
            2'b10: begin
                case (bus.fun7)
                    7'b0000000: begin
                        case (bus.fun3)
                            3'b000:  ctrl_dec = C_ADD;
                            3'b001:  ctrl_dec = C_SLL;
                            3'b010:  ctrl_dec = C_SLT;
                            3'b011:  ctrl_dec = C_SLTU;
                            3'b100:  ctrl_dec = C_XOR;
                            3'b101:  ctrl_dec = C_SRL;
                            3'b110:  ctrl_dec = C_OR;
                            default: ctrl_dec = C_AND;
                        endcase
                    end
                    7'b0100000: begin
                        if (bus.fun3 == 3'b000)      ctrl_dec = C_SUB;
                        else if (bus.fun3 == 3'b101) ctrl_dec = C_SRA;
                    end
                    7'b0000001: begin
                        if (ENABLE_MUL && bus.fun3 == 3'b000) ctrl_dec = C_MUL;
                    end
                    default: ctrl_dec = C_ILL;
                endcase
            end
            default: begin
                // I-type: fun7 is immediate bits except for the shift encodings
                case (bus.fun3)
                    3'b000:  ctrl_dec = C_ADD;
                    3'b001:  ctrl_dec = (bus.fun7 == 7'b0000000) ? C_SLL : C_ILL;
                    3'b010:  ctrl_dec = C_SLT;
                    3'b011:  ctrl_dec = C_SLTU;
                    3'b100:  ctrl_dec = C_XOR;
                    3'b101: begin
                        if (bus.fun7 == 7'b0000000)      ctrl_dec = C_SRL;
                        else if (bus.fun7 == 7'b0100000) ctrl_dec = C_SRA;
                    end
                    3'b110:  ctrl_dec = C_OR;
                    default: ctrl_dec = C_AND;
                endcase
            end
        endcase
    end

    assign shamt = bus.op_b[CW-1:0];

    always_comb begin
        alu_res = '0;
        case (ctrl_dec)
            C_AND:  alu_res = bus.op_a & bus.op_b;
            C_OR:   alu_res = bus.op_a | bus.op_b;
            C_ADD:  alu_res = bus.op_a + bus.op_b;
            C_XOR:  alu_res = bus.op_a ^ bus.op_b;
            C_SLL:  alu_res = bus.op_a << shamt;
            C_SRL:  alu_res = bus.op_a >> shamt;
            C_SUB:  alu_res = bus.op_a - bus.op_b;
            C_SRA:  alu_res = $signed(bus.op_a) >>> shamt;
            C_SLT:  alu_res = {{(XLEN-1){1'b0}}, $signed(bus.op_a) < $signed(bus.op_b)};
            C_SLTU: alu_res = {{(XLEN-1){1'b0}}, bus.op_a < bus.op_b};
            default: alu_res = '0;
        endcase
    end

    assign step_sum = acc_q + (mplier_q[0] ? mcand_q : '0);

    always_comb begin
        state_d    = state_q;
        result_d   = result_q;
        alu_ctrl_d = alu_ctrl_q;
        zero_d     = zero_q;
        illegal_d  = illegal_q;
        mcand_d    = mcand_q;
        mplier_d   = mplier_q;
        acc_d      = acc_q;
        cnt_d      = cnt_q;
        case (state_q)
            IDLE: begin
                if (bus.in_valid) begin
                    if (ctrl_dec == C_MUL) begin
                        mcand_d  = bus.op_a;
                        mplier_d = bus.op_b;
                        acc_d    = '0;
                        cnt_d    = '0;
                        state_d  = MUL_BUSY;
                    end else begin
                        result_d   = alu_res;
                        alu_ctrl_d = ctrl_dec;
                        zero_d     = (alu_res == '0);
                        illegal_d  = (ctrl_dec == C_ILL);
                        state_d    = DONE;
                    end
                end
            end
            MUL_BUSY: begin
                acc_d    = step_sum;
                mcand_d  = mcand_q << 1;
                mplier_d = mplier_q >> 1;
                cnt_d    = cnt_q + 1'b1;
                if (cnt_q == CW'(XLEN - 1)) begin
                    result_d   = step_sum;
                    alu_ctrl_d = C_MUL;
                    zero_d     = (step_sum == '0);
                    illegal_d  = 1'b0;
                    state_d    = DONE;
                end
            end
            DONE: begin
                if (bus.out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            result_q   <= '0;
            alu_ctrl_q <= 4'b0000;
            zero_q     <= 1'b0;
            illegal_q  <= 1'b0;
            mcand_q    <= '0;
            mplier_q   <= '0;
            acc_q      <= '0;
            cnt_q      <= '0;
        end else begin
            state_q    <= state_d;
            result_q   <= result_d;
            alu_ctrl_q <= alu_ctrl_d;
            zero_q     <= zero_d;
            illegal_q  <= illegal_d;
            mcand_q    <= mcand_d;
            mplier_q   <= mplier_d;
            acc_q      <= acc_d;
            cnt_q      <= cnt_d;
        end
    end

    assign bus.in_ready  = (state_q == IDLE);
    assign bus.out_valid = (state_q == DONE);
    assign bus.result    = result_q;
    assign bus.zero      = zero_q;
    assign bus.alu_ctrl  = alu_ctrl_q;
    assign bus.illegal   = illegal_q;
    assign bus.state_dbg = state_q;
endmodule
